// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared constants for the single-bus CPU datapath: data width, register
// count, ALU operation codes and a small priority helper used by the bus
// encoder.
package datapath_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_GPR = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Index of the lowest set bit; the lowest-numbered GPR wins the bus.
  function automatic logic [3:0] first_set(input logic [NUM_GPR-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_GPR - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu
// Purely combinational ALU. A comes from the Y register, B from the bus.
// Ports:
//   a       in  32  operand A (Y)
//   b       in  32  operand B (bus); b[4:0] is the shift/rotate amount
//   op_sel  in  5   operation code (OP_* in datapath_pkg)
//   result  out 64  {hi, lo}; 32-bit operations leave the upper half 0
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          op_sel,
  output logic [2*DATA_W-1:0] result
);

  logic [4:0]         shamt_s;
  logic signed [63:0] a_ext_s;
  logic signed [63:0] b_ext_s;
  logic signed [63:0] div_s;
  logic [63:0]        prod_s;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic [63:0]        dbl_s;
  logic [31:0]        ror_s;
  logic [31:0]        rol_s;
  logic [31:0]        shra_s;

  assign shamt_s = b[4:0];
  assign a_ext_s = {{32{a[31]}}, a};
  assign b_ext_s = {{32{b[31]}}, b};

  // Divisor forced to 1 on zero so the divider never sees 0; the result is
  // discarded below in that case anyway.
  assign div_s   = (b == 32'h0) ? 64'sd1 : b_ext_s;

  // 64-bit signed arithmetic keeps -2^31 / -1 well defined (wraps to 2^31).
  assign prod_s  = a_ext_s * b_ext_s;
  assign quot_s  = 32'(a_ext_s / div_s);
  assign rem_s   = 32'(a_ext_s % div_s);

  // Rotates via a doubled word, so an amount of 0 needs no special case.
  assign dbl_s   = {a, a};
  assign ror_s   = 32'(dbl_s >> shamt_s);
  assign rol_s   = 32'((dbl_s << shamt_s) >> 32);
  assign shra_s  = $signed(a) >>> shamt_s;

  // Operation select; unknown codes produce 0.
  always_comb begin
    result = 64'h0;
    case (op_sel)
      OP_ADD:  result = {32'h0, a + b};
      OP_SUB:  result = {32'h0, a - b};
      OP_AND:  result = {32'h0, a & b};
      OP_OR:   result = {32'h0, a | b};
      OP_SHR:  result = {32'h0, a >> shamt_s};
      OP_SHRA: result = {32'h0, shra_s};
      OP_SHL:  result = {32'h0, a << shamt_s};
      OP_ROR:  result = {32'h0, ror_s};
      OP_ROL:  result = {32'h0, rol_s};
      OP_MUL:  result = prod_s;
      OP_DIV:  result = (b == 32'h0) ? 64'h0 : {rem_s, quot_s};
      OP_NEG:  result = {32'h0, 32'h0 - b};
      OP_NOT:  result = {32'h0, ~b};
      default: result = 64'h0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// datapath
// Single-bus 32-bit CPU datapath: 16 GPRs, PC, IR, MAR, MDR, Y, Z (64-bit),
// HI, LO and an ALU, all exchanging data over one combinational bus. Every
// strobe comes from an external control unit.
// Ports:
//   clk, clr                     clock, async active-low clear
//   R_rd / R_wrt        [15:0]   GPR load / bus-drive enables
//   *_out                        bus-drive enables (HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C)
//   *_rd                         register load enables (MAR, Z, PC, MDR, IR, Y)
//   IncPC, Read, op_sel, Mdatain PC increment, MDR source select, ALU op, memory data
//   *_view, BusMuxOut, Data_view debug outputs
module datapath
  import datapath_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic [NUM_GPR-1:0]  R_rd,
  input  logic [NUM_GPR-1:0]  R_wrt,
  input  logic                HI_out,
  input  logic                LO_out,
  input  logic                Zhi_out,
  input  logic                Zlo_out,
  input  logic                PC_out,
  input  logic                MDR_out,
  input  logic                MAR_out,
  input  logic                In_out,
  input  logic                C_out,
  input  logic                MAR_rd,
  input  logic                Zlo_rd,
  input  logic                PC_rd,
  input  logic                MDR_rd,
  input  logic                IR_rd,
  input  logic                Y_rd,
  input  logic                IncPC,
  input  logic                Read,
  input  logic [4:0]          op_sel,
  input  logic [DATA_W-1:0]   Mdatain,
  output logic [DATA_W-1:0]   r3_view,
  output logic [DATA_W-1:0]   r4_view,
  output logic [DATA_W-1:0]   r7_view,
  output logic [DATA_W-1:0]   Y_view,
  output logic [DATA_W-1:0]   Zlo_view,
  output logic [DATA_W-1:0]   MDR_view,
  output logic [DATA_W-1:0]   PC_view,
  output logic [DATA_W-1:0]   BusMuxOut,
  output logic [DATA_W-1:0]   Data_view
);

  logic [DATA_W-1:0]   gpr_r [NUM_GPR];
  logic [DATA_W-1:0]   pc_r;
  logic [DATA_W-1:0]   mar_r;
  logic [DATA_W-1:0]   mdr_r;
  logic [DATA_W-1:0]   y_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic [2*DATA_W-1:0] z_r;
  // Only the 19-bit immediate field of IR is ever consumed in this datapath.
  logic [18:0]         ir_imm_r;

  logic [DATA_W-1:0]   bus_s;
  logic [DATA_W-1:0]   c_ext_s;
  logic [DATA_W-1:0]   mdr_in_s;
  logic [2*DATA_W-1:0] alu_res_s;
  logic                hi_lo_wr_s;

  assign c_ext_s    = {{13{ir_imm_r[18]}}, ir_imm_r};
  assign mdr_in_s   = Read ? Mdatain : bus_s;
  assign hi_lo_wr_s = Zlo_rd && ((op_sel == OP_MUL) || (op_sel == OP_DIV));

  // Bus encoder: fixed priority, GPRs first (lowest index), then HI..C.
  always_comb begin
    bus_s = 32'h0;
    if (|R_wrt) begin
      bus_s = gpr_r[first_set(R_wrt)];
    end else if (HI_out) begin
      bus_s = hi_r;
    end else if (LO_out) begin
      bus_s = lo_r;
    end else if (Zhi_out) begin
      bus_s = z_r[63:32];
    end else if (Zlo_out) begin
      bus_s = z_r[31:0];
    end else if (PC_out) begin
      bus_s = pc_r;
    end else if (MDR_out) begin
      bus_s = mdr_r;
    end else if (MAR_out) begin
      bus_s = mar_r;
    end else if (In_out) begin
      bus_s = 32'h0;
    end else if (C_out) begin
      bus_s = c_ext_s;
    end else begin
      bus_s = 32'h0;
    end
  end

  datapath_alu u_alu (
    .a      (y_r),
    .b      (bus_s),
    .op_sel (op_sel),
    .result (alu_res_s)
  );

  // General-purpose register file, each loaded from the bus.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_r[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (R_rd[i]) begin
          gpr_r[i] <= bus_s;
        end
      end
    end
  end

  // Program counter: a bus load takes precedence over increment.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_r <= 32'h0;
    end else if (PC_rd) begin
      pc_r <= bus_s;
    end else if (IncPC) begin
      pc_r <= pc_r + 32'd1;
    end
  end

  // Memory interface and operand registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mar_r    <= 32'h0;
      mdr_r    <= 32'h0;
      y_r      <= 32'h0;
      ir_imm_r <= 19'h0;
    end else begin
      if (MAR_rd) mar_r    <= bus_s;
      if (MDR_rd) mdr_r    <= mdr_in_s;
      if (Y_rd)   y_r      <= bus_s;
      if (IR_rd)  ir_imm_r <= bus_s[18:0];
    end
  end

  // ALU result registers; HI/LO capture only multiply and divide results.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_r  <= 64'h0;
      hi_r <= 32'h0;
      lo_r <= 32'h0;
    end else begin
      if (Zlo_rd) z_r <= alu_res_s;
      if (hi_lo_wr_s) begin
        hi_r <= alu_res_s[63:32];
        lo_r <= alu_res_s[31:0];
      end
    end
  end

  assign r3_view   = gpr_r[3];
  assign r4_view   = gpr_r[4];
  assign r7_view   = gpr_r[7];
  assign Y_view    = y_r;
  assign Zlo_view  = z_r[31:0];
  assign MDR_view  = mdr_r;
  assign PC_view   = pc_r;
  assign BusMuxOut = bus_s;
  // Mdatain passes straight through this mux, so it is held at 0 while cleared.
  assign Data_view = clr ? mdr_in_s : 32'h0;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath
// Self-checking bench for datapath: directed sequences plus randomized
// control strobes checked against a behavioural register-level model.
module tb_datapath;

  logic        clk;
  logic        clr;
  logic [15:0] R_rd, R_wrt;
  logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read;
  logic [4:0]  op_sel;
  logic [31:0] Mdatain;
  logic [31:0] r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view;
  logic [31:0] BusMuxOut, Data_view;

  datapath dut (
    .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
    .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .Mdatain(Mdatain),
    .r3_view(r3_view), .r4_view(r4_view), .r7_view(r7_view), .Y_view(Y_view),
    .Zlo_view(Zlo_view), .MDR_view(MDR_view), .PC_view(PC_view),
    .BusMuxOut(BusMuxOut), .Data_view(Data_view)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r_rd;
    logic [15:0] r_wrt;
    logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, mar_out, in_out, c_out;
    logic mar_rd, zlo_rd, pc_rd, mdr_rd, ir_rd, y_rd, inc_pc, read;
    logic [4:0]  op;
    logic [31:0] mdatain;
  } ctrl_t;

  localparam logic [4:0] OPS [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                      5'b10000, 5'b10001, 5'b10010, 5'b00000};

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state of the architectural registers.
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_pc = 32'h0; m_ir = 32'h0; m_mar = 32'h0; m_mdr = 32'h0;
    m_y = 32'h0; m_hi = 32'h0; m_lo = 32'h0; m_z = 64'h0;
  endtask

  function automatic logic [31:0] model_bus(input ctrl_t c);
    for (int i = 0; i < 16; i++) if (c.r_wrt[i]) return m_r[i];
    if (c.hi_out)  return m_hi;
    if (c.lo_out)  return m_lo;
    if (c.zhi_out) return m_z[63:32];
    if (c.zlo_out) return m_z[31:0];
    if (c.pc_out)  return m_pc;
    if (c.mdr_out) return m_mdr;
    if (c.mar_out) return m_mar;
    if (c.in_out)  return 32'h0;
    if (c.c_out)   return {{13{m_ir[18]}}, m_ir[18:0]};
    return 32'h0;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    int n;
    logic [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    t  = a;
    case (op)
      5'b00011: return {32'h0, a + b};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a & b};
      5'b00110: return {32'h0, a | b};
      5'b00111: return {32'h0, a >> n};
      5'b01000: begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
      5'b01001: return {32'h0, a << n};
      5'b01010: begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'b01011: begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'b01111: return 64'(sa * sb);
      5'b10000: begin
        if (b == 32'h0) return 64'h0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'b10001: return {32'h0, 32'h0 - b};
      5'b10010: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic drive(input ctrl_t c);
    R_rd = c.r_rd; R_wrt = c.r_wrt;
    HI_out = c.hi_out; LO_out = c.lo_out; Zhi_out = c.zhi_out; Zlo_out = c.zlo_out;
    PC_out = c.pc_out; MDR_out = c.mdr_out; MAR_out = c.mar_out; In_out = c.in_out;
    C_out = c.c_out; MAR_rd = c.mar_rd; Zlo_rd = c.zlo_rd; PC_rd = c.pc_rd;
    MDR_rd = c.mdr_rd; IR_rd = c.ir_rd; Y_rd = c.y_rd; IncPC = c.inc_pc; Read = c.read;
    op_sel = c.op; Mdatain = c.mdatain;
  endtask

  task automatic check_views(input string tag);
    check_eq({tag, "_r3"},  r3_view,  m_r[3]);
    check_eq({tag, "_r4"},  r4_view,  m_r[4]);
    check_eq({tag, "_r7"},  r7_view,  m_r[7]);
    check_eq({tag, "_y"},   Y_view,   m_y);
    check_eq({tag, "_zlo"}, Zlo_view, m_z[31:0]);
    check_eq({tag, "_mdr"}, MDR_view, m_mdr);
    check_eq({tag, "_pc"},  PC_view,  m_pc);
  endtask

  // One bus cycle: drive at negedge, check the bus, advance the model at posedge.
  task automatic run_cycle(input ctrl_t c);
    logic [31:0] nb;
    logic [63:0] alu;
    @(negedge clk);
    drive(c);
    #1;
    nb  = model_bus(c);
    alu = alu_ref(c.op, m_y, nb);
    check_eq("bus", BusMuxOut, nb);
    check_eq("data_view", Data_view, c.read ? c.mdatain : nb);
    for (int i = 0; i < 16; i++) if (c.r_rd[i]) m_r[i] = nb;
    if (c.mdr_rd) m_mdr = c.read ? c.mdatain : nb;
    if (c.mar_rd) m_mar = nb;
    if (c.ir_rd)  m_ir  = nb;
    if (c.y_rd)   m_y   = nb;
    if (c.pc_rd)       m_pc = nb;
    else if (c.inc_pc) m_pc = m_pc + 32'd1;
    if (c.zlo_rd) begin
      m_z = alu;
      if (c.op == 5'b01111 || c.op == 5'b10000) begin
        m_hi = alu[63:32];
        m_lo = alu[31:0];
      end
    end
    @(posedge clk);
    #1;
    check_views("post");
  endtask

  task automatic load_mdr(input logic [31:0] v);
    ctrl_t c;
    c = idle(); c.read = 1'b1; c.mdr_rd = 1'b1; c.mdatain = v;
    run_cycle(c);
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    ctrl_t c;
    load_mdr(v);
    c = idle(); c.mdr_out = 1'b1; c.r_rd[n] = 1'b1;
    run_cycle(c);
  endtask

  task automatic do_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    ctrl_t c;
    load_mdr(a);
    c = idle(); c.mdr_out = 1'b1; c.y_rd = 1'b1; run_cycle(c);
    load_mdr(b);
    c = idle(); c.mdr_out = 1'b1; c.op = op; c.zlo_rd = 1'b1; run_cycle(c);
  endtask

  task automatic show_on_bus(input int k);
    ctrl_t c;
    c = idle();
    case (k)
      0: c.hi_out = 1'b1;
      1: c.lo_out = 1'b1;
      2: c.zhi_out = 1'b1;
      default: c.c_out = 1'b1;
    endcase
    run_cycle(c);
  endtask

  function automatic ctrl_t add_driver(input ctrl_t c, input int k);
    ctrl_t d;
    d = c;
    if (k < 16) d.r_wrt[k] = 1'b1;
    else case (k)
      16: d.hi_out = 1'b1;   17: d.lo_out = 1'b1;  18: d.zhi_out = 1'b1;
      19: d.zlo_out = 1'b1;  20: d.pc_out = 1'b1;  21: d.mdr_out = 1'b1;
      22: d.mar_out = 1'b1;  23: d.in_out = 1'b1;  24: d.c_out = 1'b1;
      default: d = d;
    endcase
    return d;
  endfunction

  initial begin
    ctrl_t c;
    model_reset();
    drive(idle());
    clr = 1'b0;
    #12;
    check_views("por");
    check_eq("por_bus", BusMuxOut, 32'h0);
    @(negedge clk);
    clr = 1'b1;

    // Register loads through MDR.
    load_reg(3, 32'h96);
    load_reg(4, 32'h14);
    load_reg(7, 32'h4);
    check_eq("ld_r3", r3_view, 32'h96);
    check_eq("ld_r4", r4_view, 32'h14);
    check_eq("ld_r7", r7_view, 32'h4);

    // Logical shift right 0x96 >> 4.
    c = idle(); c.r_wrt[3] = 1'b1; c.y_rd = 1'b1; run_cycle(c);
    c = idle(); c.r_wrt[7] = 1'b1; c.op = 5'b00111; c.zlo_rd = 1'b1; run_cycle(c);
    c = idle(); c.zlo_out = 1'b1; c.r_rd[4] = 1'b1; run_cycle(c);
    check_eq("shr_r4", r4_view, 32'h9);

    // PC load, increment, wrap, and load-over-increment priority.
    load_mdr(32'h7);
    c = idle(); c.mdr_out = 1'b1; c.pc_rd = 1'b1; run_cycle(c);
    c = idle(); c.inc_pc = 1'b1; run_cycle(c);
    check_eq("pc_inc", PC_view, 32'h8);
    load_mdr(32'hFFFFFFFF);
    c = idle(); c.mdr_out = 1'b1; c.pc_rd = 1'b1; run_cycle(c);
    c = idle(); c.inc_pc = 1'b1; run_cycle(c);
    check_eq("pc_wrap", PC_view, 32'h0);
    load_mdr(32'h5);
    c = idle(); c.mdr_out = 1'b1; c.pc_rd = 1'b1; c.inc_pc = 1'b1; run_cycle(c);
    check_eq("pc_rd_wins", PC_view, 32'h5);

    // IR load and sign-extended immediate of IR[18:0].
    load_mdr(32'h2A2B8000);
    c = idle(); c.mdr_out = 1'b1; c.ir_rd = 1'b1; run_cycle(c);
    show_on_bus(3);
    check_eq("c_pos", BusMuxOut, 32'h00038000);
    load_mdr(32'h2A2C8000);
    c = idle(); c.mdr_out = 1'b1; c.ir_rd = 1'b1; run_cycle(c);
    show_on_bus(3);
    check_eq("c_neg", BusMuxOut, 32'hFFFC8000);

    // ALU sweep.
    do_alu(32'h80000001, 32'h1, 5'b01000); check_eq("shra", Zlo_view, 32'hC0000000);
    do_alu(32'h80000001, 32'h1, 5'b01010); check_eq("ror",  Zlo_view, 32'hC0000000);
    do_alu(32'h80000001, 32'h1, 5'b01011); check_eq("rol",  Zlo_view, 32'h00000003);
    do_alu(32'hFFFFFFFD, 32'h4, 5'b01111); check_eq("mul_lo", Zlo_view, 32'hFFFFFFF4);
    show_on_bus(2); check_eq("mul_hi", BusMuxOut, 32'hFFFFFFFF);
    do_alu(32'h7, 32'h2, 5'b10000);
    show_on_bus(1); check_eq("div_lo", BusMuxOut, 32'h3);
    show_on_bus(0); check_eq("div_hi", BusMuxOut, 32'h1);
    do_alu(32'h7, 32'h0, 5'b10000); check_eq("div0_lo", Zlo_view, 32'h0);
    show_on_bus(2); check_eq("div0_hi", BusMuxOut, 32'h0);
    do_alu(32'h1, 32'h5, 5'b10001); check_eq("neg", Zlo_view, 32'hFFFFFFFB);
    do_alu(32'hFFFFFFFF, 32'h1, 5'b00011); check_eq("add_wrap", Zlo_view, 32'h0);
    do_alu(32'h12345678, 32'h1, 5'b11111); check_eq("bad_op", Zlo_view, 32'h0);

    // Randomized control streams.
    for (int it = 0; it < 400; it++) begin
      c = idle();
      if ($urandom_range(0, 9) != 0) c = add_driver(c, $urandom_range(0, 25));
      if ($urandom_range(0, 3) == 0) c = add_driver(c, $urandom_range(0, 25));
      c.r_rd    = 16'($urandom) & 16'($urandom) & 16'($urandom);
      c.mar_rd  = ($urandom_range(0, 3) == 0);
      c.zlo_rd  = ($urandom_range(0, 1) == 0);
      c.pc_rd   = ($urandom_range(0, 5) == 0);
      c.mdr_rd  = ($urandom_range(0, 1) == 0);
      c.ir_rd   = ($urandom_range(0, 3) == 0);
      c.y_rd    = ($urandom_range(0, 2) == 0);
      c.inc_pc  = ($urandom_range(0, 2) == 0);
      c.read    = ($urandom_range(0, 1) == 0);
      c.op      = ($urandom_range(0, 7) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 13)];
      case ($urandom_range(0, 3))
        0:       c.mdatain = 32'($urandom_range(0, 40)) - 32'd20;
        1:       c.mdatain = 32'h80000000;
        default: c.mdatain = $urandom;
      endcase
      run_cycle(c);
    end

    // Asynchronous clear in the middle of a cycle.
    @(posedge clk);
    #2;
    c = idle(); c.read = 1'b1; c.mdr_rd = 1'b1; c.mdatain = 32'hDEADBEEF;
    c.pc_out = 1'b1; c.zlo_rd = 1'b1; c.op = 5'b10010; c.inc_pc = 1'b1;
    drive(c);
    #1;
    clr = 1'b0;
    #1;
    model_reset();
    check_views("clr");
    check_eq("clr_bus", BusMuxOut, 32'h0);
    check_eq("clr_data", Data_view, 32'h0);
    @(posedge clk);
    #1;
    check_views("clr_hold");
    check_eq("clr_hold_bus", BusMuxOut, 32'h0);
    @(negedge clk);
    drive(idle());
    clr = 1'b1;
    load_reg(4, 32'hA5A5A5A5);
    check_eq("after_clr_r4", r4_view, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
